instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18: code address width.
REQ-002 SHALL have parameter WORD_SIZE, default 18: instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4: prefetch buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_ADDR, default 0: first fetch address after reset.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port code_addr  output  ADDR_SIZE  code memory read address.
REQ-008 SHALL have port code_rd  output  1  code memory read strobe.
REQ-009 SHALL have port code_word  input  WORD_SIZE  read data, valid the cycle after code_rd.
REQ-010 SHALL have port redirect  input  1  flush and restart fetch at redirect_addr.
REQ-011 SHALL have port redirect_addr  input  ADDR_SIZE  new fetch address.
REQ-012 SHALL have port instr_valid  output  1  instr_word/instr_addr hold a valid instruction.
REQ-013 SHALL have port instr_word  output  WORD_SIZE  instruction word at head of buffer.
REQ-014 SHALL have port instr_addr  output  ADDR_SIZE  address instr_word was fetched from.
REQ-015 SHALL have port instr_ready  input  1  decoder consumes head when high with instr_valid.

Function
REQ-016 Fetch pointer fptr SHALL drive code_addr; a read is issued in every cycle code_rd=1, and fptr then increments by 1, wrapping from 2^ADDR_SIZE-1 to 0.
REQ-017 code_rd SHALL be 1 only when not in reset, redirect=0, and (occupancy + in_flight) < DEPTH, using start-of-cycle values (no credit for a same-cycle pop).
REQ-018 Read issued in cycle C SHALL have code_word sampled at the end of cycle C+1 and written with its address into the buffer; instr_valid SHALL be 1 in cycle C+2 at the earliest.
REQ-019 Handshake: entry popped at end of any cycle with instr_valid=1 and instr_ready=1; instr_word/instr_addr SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-020 Buffer SHALL be FIFO order; simultaneous push and pop SHALL leave occupancy unchanged; push SHALL never occur when full (guaranteed by REQ-017).
REQ-021 instr_valid SHALL equal (occupancy != 0).
REQ-022 redirect=1 in cycle N SHALL, at end of N: empty the buffer, discard any in-flight read (its data never enters the buffer), load fptr with redirect_addr.
REQ-023 After redirect in cycle N: code_rd=1 with code_addr=redirect_addr in N+1; instr_valid=1 with that word in N+3; instr_valid=0 in N+1 and N+2.
REQ-024 redirect SHALL take priority over a same-cycle pop and push; consecutive redirect cycles SHALL each restart, the last address winning.
REQ-025 With instr_ready held 1 and no redirect, sustained throughput SHALL be one instruction per cycle.

Reset
REQ-026 During reset: code_rd=0, instr_valid=0, buffer empty, in-flight cleared, fptr loaded with RESET_ADDR at end of the reset cycle.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight data; first cycle after reset deasserts SHALL issue code_rd=1 with code_addr=RESET_ADDR.
REQ-028 code_addr SHALL equal fptr at all times (RESET_ADDR after reset); instr_word/instr_addr are don't-care while instr_valid=0.

Structure
REQ-029 ADDR_SIZE/WORD_SIZE defaults and RESET_ADDR SHALL come from shared package asm18_pkg, also used by processor.
REQ-030 Buffer SHALL be a sub-module fetch_fifo (synchronous FIFO, {addr,word} entries, count output); in-flight tracking and fptr stay in instr_fetch.

Verification
REQ-031 Reset release, instr_ready=1, memory[i]=i+100 -> code_rd in cycle 1 addr 0; instr_valid from cycle 3, words 100,101,102... one per cycle, instr_addr 0,1,2...
REQ-032 instr_ready=0 for 10 cycles -> exactly DEPTH=4 reads issued, code_rd then 0, head word/addr stable; ready=1 -> addrs 0..3 delivered, then fetch resumes at 4 without gap or duplicate.
REQ-033 redirect with redirect_addr=0x200 while buffer holds 3 entries and one read in flight -> none of the old words appear; first delivered instr_addr=0x200 exactly 3 cycles after redirect.
REQ-034 RESET_ADDR=0x3FFFE, ready=1 -> instr_addr sequence 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-035 reset asserted for one cycle with buffer full and read in flight -> instr_valid=0 next cycle, next delivered instr_addr=RESET_ADDR.
REQ-036 Randomised instr_ready (50%) over 1000 cycles with redirects every ~50 cycles -> delivered stream matches reference model address/word sequence; no overflow or underflow.

Source files
------------

// File: rtl/asm18_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | asm18_pkg : shared widths and reset vector for the asm18 processor core  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package asm18_pkg;

    localparam int unsigned ASM18_ADDR_SIZE = 18;
    localparam int unsigned ASM18_WORD_SIZE = 18;

    typedef logic [ASM18_ADDR_SIZE-1:0] asm18_addr_t;

    localparam asm18_addr_t ASM18_RESET_ADDR = '0;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned fifo_count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_fifo : synchronous prefetch FIFO of {addr,word} entries with count |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_fifo
    import asm18_pkg::*;
#(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = fifo_count_width(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop, clear;

    always_comb begin
        clear    = reset || flush;
        do_pop   = pop && (count_q != '0);
        do_push  = push && (count_q != CNT_W'(DEPTH));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
            if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch : prefetching instruction fetch unit with redirect support   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module instr_fetch
    import asm18_pkg::*;
#(
    parameter int unsigned          ADDR_SIZE  = ASM18_ADDR_SIZE,
    parameter int unsigned          WORD_SIZE  = ASM18_WORD_SIZE,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_ADDR = ADDR_SIZE'(ASM18_RESET_ADDR)
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [ADDR_SIZE-1:0] code_addr,
    output logic                 code_rd,
    input  logic [WORD_SIZE-1:0] code_word,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_addr,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr_word,
    output logic [ADDR_SIZE-1:0] instr_addr,
    input  logic                 instr_ready
);

    localparam int unsigned CNT_W   = fifo_count_width(DEPTH);
    localparam int unsigned ENTRY_W = ADDR_SIZE + WORD_SIZE;

    logic [ADDR_SIZE-1:0] fptr_q, fptr_d;
    logic [ADDR_SIZE-1:0] inflight_addr_q, inflight_addr_d;
    logic                 inflight_q, inflight_d;
    logic [CNT_W-1:0]     count, occupancy;
    logic                 push, pop;
    logic [ENTRY_W-1:0]   head;

    always_comb begin
        instr_valid = !reset && (count != '0);
        // Credit check uses start-of-cycle state only; a same-cycle pop frees no slot.
        occupancy   = count + CNT_W'(inflight_q);
        code_rd     = !reset && !redirect && (occupancy < CNT_W'(DEPTH));
        push        = inflight_q && !redirect;
        pop         = instr_valid && instr_ready;
        inflight_d      = code_rd;
        inflight_addr_d = fptr_q;
        fptr_d          = fptr_q;
        if (reset) begin
            fptr_d = RESET_ADDR;
        end else if (redirect) begin
            fptr_d = redirect_addr;
        end else if (code_rd) begin
            fptr_d = fptr_q + ADDR_SIZE'(1);
        end
    end

    always_ff @(posedge clock) begin
        fptr_q          <= fptr_d;
        inflight_q      <= inflight_d;
        inflight_addr_q <= inflight_addr_d;
    end

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data ({inflight_addr_q, code_word}),
        .pop       (pop),
        .pop_data  (head),
        .count     (count)
    );

    assign code_addr  = fptr_q;
    assign instr_addr = head[ENTRY_W-1:WORD_SIZE];
    assign instr_word = head[WORD_SIZE-1:0];

endmodule
`default_nettype wire
